// File: rtl/bioz_siggen_seq_if.sv
// Host write stream, RAM port strobes and sample output of the BioZ
// waveform playback sequencer. The master modport is the sequencer side.
interface bioz_siggen_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();
    // Host stream: a word transfers in every cycle where host_wr_valid and
    // host_wr_ready are both high; valid may drop between words at any time.
    logic                  host_wr_valid;
    logic                  host_wr_ready;
    logic [DATA_WIDTH-1:0] host_wr_data;

    // Single-port RAM, all strobes registered by the sequencer
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_oe;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Playback output
    logic [DATA_WIDTH-1:0] sample;
    logic                  sample_valid;

    modport master (
        input  host_wr_valid, host_wr_data, ram_rdata,
        output host_wr_ready, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
        output sample, sample_valid
    );

    modport slave (
        output host_wr_valid, host_wr_data, ram_rdata,
        input  host_wr_ready, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
        input  sample, sample_valid
    );
endinterface

// File: rtl/bioz_siggen_seq.sv
// Playback sequencer for the BioZ waveform RAM: loads one waveform period
// from the host stream, then replays it through a phase accumulator (DDS)
// at a programmable sample rate. Owns every RAM strobe.
module bioz_siggen_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bioz_siggen_seq_if.master    bus,
    input  logic                 load_start,
    input  logic                 play_en,
    input  logic [ACC_WIDTH-1:0] fcw,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 load_done,
    output logic                 busy,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PLAY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = 1;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ACC_WIDTH-1:0]  phase_q;
    logic [ACC_WIDTH-1:0]  fcw_l_q;
    logic [DIV_WIDTH-1:0]  presc_q;
    logic [DIV_WIDTH-1:0]  div_l_q;
    logic                  load_done_q;
    logic                  reload_q;   // load_start seen since leaving PLAY
    logic                  rd_d1_q;    // ram_rdata valid this cycle
    logic                  ram_cs_q, ram_we_q, ram_oe_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_wdata_q;
    logic [DATA_WIDTH-1:0] sample_q;
    logic                  sample_valid_q;

    logic beat, last_beat, play_exit, tick, in_flight;

    assign beat      = (state_q == LOAD) && bus.host_wr_valid;
    assign last_beat = beat && (ptr_q == '1);
    assign play_exit = load_start || !play_en;
    // Leaving PLAY suppresses a tick falling in the same cycle
    assign tick      = (state_q == PLAY) && !play_exit && (presc_q == div_l_q);
    assign in_flight = ram_oe_q || rd_d1_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_start)                  state_d = LOAD;
                else if (play_en && load_done_q) state_d = PLAY;
            end
            LOAD: begin
                if (last_beat) state_d = IDLE;
            end
            PLAY: begin
                if (play_exit) state_d = DRAIN;
            end
            DRAIN: begin
                // Wait out the read pipeline so its sample is not lost
                if (!in_flight) state_d = (reload_q || load_start) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: RAM strobes, write pointer, phase accumulator, prescaler, sample capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= '0;
            phase_q        <= '0;
            fcw_l_q        <= '0;
            presc_q        <= '0;
            div_l_q        <= '0;
            load_done_q    <= 1'b0;
            reload_q       <= 1'b0;
            rd_d1_q        <= 1'b0;
            ram_cs_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_oe_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            ram_cs_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_oe_q       <= 1'b0;
            rd_d1_q        <= ram_cs_q && ram_oe_q;
            sample_valid_q <= rd_d1_q;
            if (rd_d1_q) sample_q <= bus.ram_rdata;

            if (beat) begin
                ram_cs_q    <= 1'b1;
                ram_we_q    <= 1'b1;
                ram_addr_q  <= ptr_q;
                ram_wdata_q <= bus.host_wr_data;
                ptr_q       <= ptr_q + ADDR_ONE;
                if (last_beat) load_done_q <= 1'b1;
            end

            if (tick) begin
                ram_cs_q   <= 1'b1;
                ram_oe_q   <= 1'b1;
                ram_addr_q <= phase_q[ACC_WIDTH-1 -: ADDR_WIDTH];
                phase_q    <= phase_q + fcw_l_q;
            end

            if ((state_q == PLAY) && !play_exit)
                presc_q <= (presc_q == div_l_q) ? '0 : presc_q + DIV_ONE;

            if ((state_q != LOAD) && (state_d == LOAD)) begin
                ptr_q       <= '0;
                load_done_q <= 1'b0;
            end

            if ((state_q == IDLE) && (state_d == PLAY)) begin
                phase_q <= '0;
                presc_q <= '0;
                fcw_l_q <= fcw;
                div_l_q <= div;
            end

            if (state_q == PLAY)       reload_q <= load_start;
            else if (state_q == DRAIN) reload_q <= reload_q || load_start;
            else                       reload_q <= 1'b0;
        end
    end

    assign bus.host_wr_ready = (state_q == LOAD);
    assign bus.ram_cs        = ram_cs_q;
    assign bus.ram_we        = ram_we_q;
    assign bus.ram_oe        = ram_oe_q;
    assign bus.ram_addr      = ram_addr_q;
    assign bus.ram_wdata     = ram_wdata_q;
    assign bus.sample        = sample_q;
    assign bus.sample_valid  = sample_valid_q;
    assign load_done         = load_done_q;
    assign busy              = (state_q != IDLE);
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_bioz_siggen_seq.sv
// Bench for bioz_siggen_seq: drives host loads and playback runs with random
// waveforms, rates and gaps, and compares every sample against a DDS model.
module tb_bioz_siggen_seq;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int ACCW  = 16;
    localparam int DIVW  = 8;
    localparam int DEPTH = 256;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load_start = 1'b0;
    logic            play_en = 1'b0;
    logic [ACCW-1:0] fcw = '0;
    logic [DIVW-1:0] div = '0;
    logic            load_done;
    logic            busy;
    logic [1:0]      dbg_state;

    bioz_siggen_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bioz_siggen_seq #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW), .DIV_WIDTH(DIVW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .load_start (load_start),
        .play_en    (play_en),
        .fcw        (fcw),
        .div        (div),
        .load_done  (load_done),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM attached to the DUT ----------------
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_cs && bus.ram_oe) bus.ram_rdata <= mem[bus.ram_addr];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_load_done"}, 32'(load_done), 0);
        check({tag, "_ready"},     32'(bus.host_wr_ready), 0);
        check({tag, "_cs"},        32'(bus.ram_cs), 0);
        check({tag, "_we"},        32'(bus.ram_we), 0);
        check({tag, "_oe"},        32'(bus.ram_oe), 0);
        check({tag, "_addr"},      32'(bus.ram_addr), 0);
        check({tag, "_wdata"},     32'(bus.ram_wdata), 0);
        check({tag, "_sample"},    32'(bus.sample), 0);
        check({tag, "_svalid"},    32'(bus.sample_valid), 0);
        check({tag, "_state"},     32'(dbg_state), 0);
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] wave [DEPTH];   // waveform the bench has loaded
    logic [DW-1:0] exp_q[$];       // expected samples in order
    int            t0;             // cycle in which play_en was raised
    int            exp_div;        // divider latched at that entry
    int            k_rx;           // samples received since t0

    // Sample k of a run: phase = k*fcw mod 2^16, address = top 8 bits of phase,
    // emitted at t0 + 4 + div + k*(div+1).
    always @(negedge clk) begin
        if (bus.sample_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 32'(bus.sample_valid), 0);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check("sample", 32'(bus.sample), 32'(e));
                check("sample_time", 32'(cyc), 32'(t0 + 4 + exp_div + k_rx * (exp_div + 1)));
                k_rx++;
            end
        end
        if (bus.ram_we && bus.ram_oe) check("we_oe_exclusive", 1, 0);
    end

    task automatic start_play(input logic [ACCW-1:0] fcw_v, input logic [DIVW-1:0] div_v, input int n);
        exp_q.delete();
        for (int k = 0; k < n + 8; k++) begin
            int ph;
            ph = (k * int'(fcw_v)) % 65536;
            exp_q.push_back(wave[ph / 256]);
        end
        fcw     = fcw_v;
        div     = div_v;
        exp_div = int'(div_v);
        k_rx    = 0;
        t0      = cyc;
        play_en = 1'b1;
    endtask

    // Run until n samples arrive, then leave PLAY by dropping play_en or by
    // a load_start pulse; checks that exactly the reads issued before the exit
    // produce samples, and that the exit completes within the drain bound.
    task automatic play_run(input logic [ACCW-1:0] fcw_v, input logic [DIVW-1:0] div_v,
                            input int n, input bit by_load);
        int budget;
        int e;
        int n_exp;
        int b;
        start_play(fcw_v, div_v, n);
        step();
        check("play_state", 32'(dbg_state), 2);
        fcw = fcw_v ^ 16'h0f0f;            // ignored until next PLAY entry
        div = div_v ^ 8'h01;
        budget = (n + 2) * (int'(div_v) + 1) + 20;
        while (k_rx < n && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("play_timeout", 32'(k_rx), 32'(n));
        e = cyc;
        if (by_load) load_start = 1'b1;
        else         play_en = 1'b0;
        step();
        load_start = 1'b0;
        play_en    = 1'b0;
        b = 1;
        while ((by_load ? !bus.host_wr_ready : busy) && b < 4) begin
            step();
            b++;
        end
        n_exp = 0;
        for (int j = 0; j < 2000; j++)
            if (t0 + 1 + int'(div_v) + j * (int'(div_v) + 1) < e) n_exp++;
        check("drain_samples", 32'(k_rx), 32'(n_exp));
        if (by_load) begin
            check("reload_state", 32'(dbg_state), 1);
            check("reload_done_clr", 32'(load_done), 0);
        end else begin
            check("drain_idle", 32'(busy), 0);
            check("drain_done_kept", 32'(load_done), 1);
        end
        exp_q.delete();
    endtask

    // Feed n words of wave[] (n == DEPTH for a full load); optionally with
    // random valid gaps. Each cycle checks that a write strobe appears exactly
    // for the word accepted in the previous cycle.
    task automatic load_wave(input bit do_start, input bit gaps, input int n);
        int            i;
        int            budget;
        int            bad;
        bit            prev;
        bit            v;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pdata;
        i = 0; budget = 4 * DEPTH; prev = 1'b0; paddr = '0; pdata = '0;
        if (do_start) begin
            load_start = 1'b1;
            step();
            load_start = 1'b0;
        end
        check("ld_ready", 32'(bus.host_wr_ready), 1);
        check("ld_done_clr", 32'(load_done), 0);
        while (i < n && budget > 0) begin
            v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.host_wr_valid = v;
            bus.host_wr_data  = wave[i];
            check("wr_strobe", 32'(bus.ram_cs && bus.ram_we), 32'(prev));
            check("wr_oe", 32'(bus.ram_oe), 0);
            if (prev) begin
                check("wr_addr", 32'(bus.ram_addr), 32'(paddr));
                check("wr_data", 32'(bus.ram_wdata), 32'(pdata));
            end
            prev = v;
            if (v) begin
                paddr = AW'(i);
                pdata = wave[i];
                i++;
            end
            step();
            budget--;
        end
        bus.host_wr_valid = 1'b0;
        if (budget == 0) check("ld_timeout", 32'(i), 32'(n));
        if (n == DEPTH) begin
            check("wr_strobe_last", 32'(bus.ram_cs && bus.ram_we), 1);
            check("wr_addr_last", 32'(bus.ram_addr), 32'(paddr));
            check("wr_data_last", 32'(bus.ram_wdata), 32'(pdata));
            check("ld_done_set", 32'(load_done), 1);
            check("ld_ready_low", 32'(bus.host_wr_ready), 0);
            check("ld_busy_low", 32'(busy), 0);
            step();
            step();
            bad = 0;
            for (int a = 0; a < DEPTH; a++) if (mem[a] !== wave[a]) bad++;
            check("ram_contents", 32'(bad), 0);
        end
    endtask

    task automatic random_wave();
        for (int a = 0; a < DEPTH; a++) wave[a] = DW'($urandom_range(0, 255));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int b;
        bus.host_wr_valid = 1'b0;
        bus.host_wr_data  = '0;
        exp_div = 0; t0 = 0; k_rx = 0;

        rst_n = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // play_en without a loaded waveform: must stay idle with no strobes
        play_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check("noload_busy", 32'(busy), 0);
            check("noload_cs", 32'(bus.ram_cs), 0);
        end
        play_en = 1'b0;
        step();

        // Ramp, back-to-back
        for (int a = 0; a < DEPTH; a++) wave[a] = DW'(a);
        load_wave(1'b1, 1'b0, DEPTH);

        // Ramp, with valid gaps
        load_wave(1'b1, 1'b1, DEPTH);

        play_run(16'h0100, 8'd0, 300, 1'b0);
        step();
        play_run(16'h0180, 8'd3, 20, 1'b0);
        step();
        play_run(16'h0000, 8'd1, 6, 1'b0);
        step();

        // Random waveform and random rates
        random_wave();
        load_wave(1'b1, 1'b1, DEPTH);
        for (int r = 0; r < 3; r++) begin
            play_run(ACCW'($urandom_range(0, 65535)), DIVW'($urandom_range(0, 5)), 12, 1'b0);
            step();
        end

        // load_start during PLAY: drain then reload
        play_run(16'h0100, 8'd2, 5, 1'b1);
        random_wave();
        load_wave(1'b0, ($urandom_range(0, 1) == 1), DEPTH);
        play_run(ACCW'($urandom_range(1, 65535)), 8'd0, 40, 1'b0);
        step();

        // Reset in the middle of PLAY
        start_play(16'h0300, 8'd1, 10);
        b = 0;
        while (k_rx < 3 && b < 50) begin
            step();
            b++;
        end
        check("midplay_state", 32'(dbg_state), 2);
        #2;
        rst_n   = 1'b0;
        play_en = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("rst_play");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Reset in the middle of LOAD
        random_wave();
        load_wave(1'b1, 1'b0, 40);
        check("midload_state", 32'(dbg_state), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_load");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
